// File: rtl/y86_mem_pkg.sv
// y86_mem_pkg: shared constants and FSM encoding for the Y86-64 dual-port memory
package y86_mem_pkg;

    localparam int WORD_BYTES = 8;
    localparam int IBYTES_Y86 = 10;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

endpackage

// File: rtl/y86_byte_ram.sv
// y86_byte_ram: byte array with an 8-byte write port and two combinational read windows
module y86_byte_ram
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int IBYTES    = IBYTES_Y86,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic                clock,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [63:0]         wdata,
    input  logic [AW-1:0]       raddr,
    output logic [63:0]         rdata,
    input  logic [AW-1:0]       iaddr,
    output logic [8*IBYTES-1:0] idata
);

    logic [7:0] mem [MEM_BYTES];

    // little-endian 8-byte store at any byte offset
    always_ff @(posedge clock) begin
        if (we)
            for (int k = 0; k < WORD_BYTES; k++)
                mem[waddr + AW'(k)] <= wdata[8*k +: 8];
    end

    // data window: byte 0 of the word lands in bits [7:0]
    always_comb begin
        rdata = '0;
        for (int k = 0; k < WORD_BYTES; k++)
            rdata[8*k +: 8] = mem[raddr + AW'(k)];
    end

    // fetch window: byte 0 (mem[pc]) lands in bits [7:0]
    always_comb begin
        idata = '0;
        for (int k = 0; k < IBYTES; k++)
            idata[8*k +: 8] = mem[iaddr + AW'(k)];
    end

endmodule

// File: rtl/y86_dual_port_mem.sv
// y86_dual_port_mem: Y86-64 memory with registered fetch port and handshaked data port
module y86_dual_port_mem
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int LATENCY   = 1,
    parameter int IBYTES    = IBYTES_Y86,
    parameter int ADDR_W    = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   i_pc,
    output logic [8*IBYTES-1:0] i_bytes,
    output logic                i_ok,
    input  logic                m_req,
    input  logic                m_write,
    input  logic [ADDR_W-1:0]   m_addr,
    input  logic [63:0]         m_wdata,
    output logic                m_ready,
    output logic                m_rvalid,
    output logic [63:0]         m_rdata,
    output logic                m_ok,
    output logic                init_done
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int NW = MEM_BYTES / WORD_BYTES;
    localparam int SW = AW - 3;
    localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(MEM_BYTES);

    state_t state, next_state;
    logic [3:0] cnt;
    logic [SW-1:0] sweep;
    logic lw;
    logic [ADDR_W-1:0] la;
    logic accept, m_fit, l_fit, i_fit, we;
    logic [AW-1:0] waddr;
    logic [63:0] wdata, rdata;
    logic [8*IBYTES-1:0] idata;

    // one extra address bit so an access near the top of the address space cannot wrap into range
    assign m_fit = ({1'b0, m_addr} + (ADDR_W+1)'(WORD_BYTES)) <= LIM;
    assign l_fit = ({1'b0, la} + (ADDR_W+1)'(WORD_BYTES)) <= LIM;
    assign i_fit = ({1'b0, i_pc} + (ADDR_W+1)'(IBYTES)) <= LIM;

    assign accept = (state == IDLE) && m_req;
    assign we     = (state == INIT) || (accept && m_write && m_fit);
    assign waddr  = (state == INIT) ? {sweep, 3'b000} : m_addr[AW-1:0];
    assign wdata  = (state == INIT) ? 64'h0 : m_wdata;

    assign m_ready  = state == IDLE;
    assign m_rvalid = state == RESP;
    assign m_ok     = m_rvalid && l_fit;
    assign m_rdata  = (m_ok && !lw) ? rdata : 64'h0;

    y86_byte_ram #(.MEM_BYTES(MEM_BYTES), .IBYTES(IBYTES), .AW(AW)) ram (
        .clock(clock),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(la[AW-1:0]),
        .rdata(rdata),
        .iaddr(i_pc[AW-1:0]),
        .idata(idata)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= INIT;
        else       state <= next_state;
    end

    // next state: sweep, accept, wait out the latency, respond
    always_comb begin
        next_state = state;
        unique case (state)
            INIT:    next_state = (sweep == SW'(NW-1)) ? IDLE : INIT;
            IDLE:    next_state = m_req ? ((LATENCY == 0) ? RESP : WAIT) : IDLE;
            WAIT:    next_state = (cnt == 4'd0) ? RESP : WAIT;
            default: next_state = IDLE;
        endcase
    end

    // sweep counter, wait counter and the latched request
    always_ff @(posedge clock) begin
        if (reset) begin
            sweep     <= '0;
            cnt       <= '0;
            lw        <= 1'b0;
            la        <= '0;
            init_done <= 1'b0;
        end else begin
            if (state == INIT) sweep <= sweep + 1'b1;
            if (state == INIT && next_state == IDLE) init_done <= 1'b1;
            if (accept) begin
                lw  <= m_write;
                la  <= m_addr;
                cnt <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // registered fetch; samples memory before any store committing on the same edge
    always_ff @(posedge clock) begin
        if (reset) begin
            i_ok    <= 1'b0;
            i_bytes <= '0;
        end else begin
            i_ok    <= (state != INIT) && i_fit;
            i_bytes <= ((state != INIT) && i_fit) ? idata : '0;
        end
    end

endmodule

// File: tb/tb_y86_dual_port_mem.sv
// tb_y86_dual_port_mem: directed checks of init sweep, data handshake, bounds and fetch port
module tb_y86_dual_port_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, a_iok, a_req, a_write, a_ready, a_rvalid, a_ok, a_done;
    logic [63:0] a_pc, a_addr, a_wdata, a_rdata;
    logic [79:0] a_ib;
    logic b_rst, b_iok, b_req, b_write, b_ready, b_rvalid, b_ok, b_done;
    logic [63:0] b_pc, b_addr, b_wdata, b_rdata;
    logic [79:0] b_ib;

    int total = 0;
    int bad = 0;

    y86_dual_port_mem dut_a (
        .clock(clk), .reset(a_rst), .i_pc(a_pc), .i_bytes(a_ib), .i_ok(a_iok),
        .m_req(a_req), .m_write(a_write), .m_addr(a_addr), .m_wdata(a_wdata),
        .m_ready(a_ready), .m_rvalid(a_rvalid), .m_rdata(a_rdata), .m_ok(a_ok),
        .init_done(a_done)
    );

    y86_dual_port_mem #(.MEM_BYTES(64), .LATENCY(3)) dut_b (
        .clock(clk), .reset(b_rst), .i_pc(b_pc), .i_bytes(b_ib), .i_ok(b_iok),
        .m_req(b_req), .m_write(b_write), .m_addr(b_addr), .m_wdata(b_wdata),
        .m_ready(b_ready), .m_rvalid(b_rvalid), .m_rdata(b_rdata), .m_ok(b_ok),
        .init_done(b_done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [63:0] addr, input logic [63:0] wd,
                        output logic [63:0] rd, output logic ok, output int lat);
        int n;
        a_req = 1'b1; a_write = w; a_addr = addr; a_wdata = wd;
        n = 0;
        while (!a_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        a_req = 1'b0; a_write = 1'b0;
        lat = 1;
        while (!a_rvalid && lat < 50) begin @(negedge clk); lat++; end
        rd = a_rdata; ok = a_ok;
        @(negedge clk);
    endtask

    task automatic fetch(input string tag, input logic [63:0] pc, input logic ok, input logic [79:0] bytes);
        a_pc = pc;
        @(negedge clk);
        check({tag, " iok"}, a_iok, ok);
        check({tag, " ibytes"}, a_ib, bytes);
    endtask

    initial begin
        logic [63:0] rd;
        logic ok, early, seen;
        logic [10:1] rdy_v, val_v;
        logic [63:0] b_rd;
        logic b_okv;
        int lat, n;
        a_rst = 1; a_pc = 0; a_req = 0; a_write = 0; a_addr = 0; a_wdata = 0;
        b_rst = 1; b_pc = 0; b_req = 0; b_write = 0; b_addr = 0; b_wdata = 0;
        b_rd = 0; b_okv = 0;
        @(negedge clk); @(negedge clk);
        check("rst ready", a_ready, 0);
        check("rst rvalid", a_rvalid, 0);
        check("rst done", a_done, 0);
        check("rst iok", a_iok, 0);
        check("rst ibytes", a_ib, 0);
        check("rst rdata", a_rdata, 0);
        a_rst = 0; b_rst = 0;
        n = 0; early = 0;
        while (!a_done && n < 3000) begin
            @(negedge clk); n++;
            if (!a_done && (a_ready || a_iok)) early = 1;
        end
        check("init cycles", n, 1024);
        check("init quiet", early, 0);
        check("init last iok", a_iok, 0);
        check("b init done", b_done, 1);
        @(negedge clk);
        check("idle ready", a_ready, 1);
        fetch("idle fetch0", 0, 1, 80'h0);

        xfer(1, 0, 64'h0123456789abcdef, rd, ok, lat);
        check("st0 ok", ok, 1);
        check("st0 rdata", rd, 0);
        check("st0 lat", lat, 2);
        xfer(0, 2, 0, rd, ok, lat);
        check("ld2 rdata", rd, 64'h0000_0123_4567_89ab);
        check("ld2 ok", ok, 1);
        check("ld2 lat", lat, 2);

        xfer(1, 3, 64'h0123456789abcdef, rd, ok, lat);
        check("st3 ok", ok, 1);
        fetch("fetch0", 0, 1, 80'h2345_6789_abcd_efab_cdef);
        fetch("fetch5", 5, 1, 80'h0000_0000_0123_4567_89ab);

        fetch("fetch16 pre", 16, 1, 80'h0);
        a_req = 1; a_write = 1; a_addr = 16; a_wdata = 64'h1122334455667788;
        @(negedge clk);
        a_req = 0; a_write = 0;
        check("same-cycle fetch", a_ib, 80'h0);
        @(negedge clk);
        check("post-store fetch", a_ib, 80'h0000_1122_3344_5566_7788);
        check("st16 rvalid", a_rvalid, 1);
        @(negedge clk);

        xfer(1, 8185, 64'hffff_ffff_ffff_ffff, rd, ok, lat);
        check("st8185 ok", ok, 0);
        check("st8185 rdata", rd, 0);
        xfer(0, 8184, 0, rd, ok, lat);
        check("ld8184 zero", rd, 0);
        check("ld8184 ok", ok, 1);
        xfer(0, 8185, 0, rd, ok, lat);
        check("ld8185 ok", ok, 0);
        xfer(0, 64'hffff_ffff_ffff_fffc, 0, rd, ok, lat);
        check("ldwrap ok", ok, 0);
        check("ldwrap rdata", rd, 0);
        xfer(1, 8184, 64'hdeadbeefcafef00d, rd, ok, lat);
        check("st8184 ok", ok, 1);
        xfer(0, 8184, 0, rd, ok, lat);
        check("ld8184 data", rd, 64'hdeadbeefcafef00d);
        fetch("fetch8183", 8183, 0, 80'h0);
        fetch("fetch8182", 8182, 1, 80'hdead_beef_cafe_f00d_0000);
        fetch("fetchwrap", 64'hffff_ffff_ffff_fff8, 0, 80'h0);

        check("b ready", b_ready, 1);
        b_req = 1; b_write = 1; b_addr = 0; b_wdata = 64'h55aa_1234_8765_aa55;
        @(negedge clk);
        b_req = 0; b_write = 0;
        repeat (4) @(negedge clk);
        b_req = 1; b_addr = 0;
        for (int c = 1; c <= 10; c++) begin
            rdy_v[c] = b_ready;
            val_v[c] = b_rvalid;
            if (b_rvalid) begin b_rd = b_rdata; b_okv = b_ok; end
            if (c == 6) b_req = 0;
            @(negedge clk);
        end
        check("lat3 ready", rdy_v, 10'b1111100001);
        check("lat3 rvalid", val_v, 10'b0000010000);
        check("lat3 rdata", b_rd, 64'h55aa_1234_8765_aa55);
        check("lat3 ok", b_okv, 1);

        a_pc = 0;
        a_req = 1; a_write = 0; a_addr = 0;
        @(negedge clk);
        a_req = 0;
        a_rst = 1;
        @(negedge clk);
        check("rst wait rvalid", a_rvalid, 0);
        check("rst wait ready", a_ready, 0);
        check("rst wait done", a_done, 0);
        a_rst = 0;
        n = 0; seen = 0;
        while (!a_done && n < 3000) begin
            @(negedge clk); n++;
            if (a_rvalid) seen = 1;
        end
        check("reinit cycles", n, 1024);
        check("reinit no rvalid", seen, 0);
        @(negedge clk);
        xfer(0, 0, 0, rd, ok, lat);
        check("reinit ld0", rd, 0);
        check("reinit ld0 ok", ok, 1);
        xfer(0, 8184, 0, rd, ok, lat);
        check("reinit ld8184", rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
